// File: rtl/scrambler_frame_tx.sv
// 802.11a transmit framer: all-ones preamble, raw SIGNAL field, x^7+x^4+1 scrambled DATA field.
// Optional TX_TAIL_ZERO_EN forces the last 6 scrambled DATA bits to zero.
module scrambler_frame_tx #(
   parameter int unsigned PREAMBLE_LEN = 12,
   parameter int unsigned SIGNAL_LEN   = 24,
   parameter int unsigned DATA_LEN     = 48,
   parameter logic [6:0]  SEED         = 7'h7F
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   input  logic In_data,
   input  logic In_valid,
   output logic In_ready,
   output logic Out,
   output logic Out_valid,
   output logic Busy,
   output logic Done
);

   localparam int unsigned MaxLen0 = (PREAMBLE_LEN > SIGNAL_LEN) ? PREAMBLE_LEN : SIGNAL_LEN;
   localparam int unsigned MaxLen  = (MaxLen0 > DATA_LEN) ? MaxLen0 : DATA_LEN;
   localparam int unsigned CntW    = $clog2(MaxLen + 1);

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StSignal,
      StData,
      StDone
   } state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [6:0]      lfsr_q, lfsr_d;
   logic            out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            xfer;
   logic            fb;

   assign In_ready  = (state_q == StSignal) || (state_q == StData);
   assign xfer      = In_valid & In_ready;
   assign fb        = lfsr_q[6] ^ lfsr_q[3];
   assign Out       = out_q;
   assign Out_valid = out_valid_q;
   assign Busy      = busy_q;
   assign Done      = done_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         lfsr_q      <= SEED;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lfsr_d      = lfsr_q;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d = StPreamble;
               cnt_d   = '0;
               lfsr_d  = SEED;
               busy_d  = 1'b1;
            end
         end
         StPreamble: begin
            out_d       = 1'b1;
            out_valid_d = 1'b1;
            if (cnt_q == CntW'(PREAMBLE_LEN - 1)) begin
               state_d = StSignal;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSignal: begin
            if (xfer) begin
               out_d       = In_data;
               out_valid_d = 1'b1;
               if (cnt_q == CntW'(SIGNAL_LEN - 1)) begin
                  state_d = StData;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StData: begin
            if (xfer) begin
               out_d       = In_data ^ fb;
`ifdef TX_TAIL_ZERO_EN
               // Tail bits still consume input and clock the LFSR; only the output is zeroed.
               if (cnt_q >= CntW'(DATA_LEN - 6)) begin
                  out_d = 1'b0;
               end
`endif
               out_valid_d = 1'b1;
               lfsr_d      = {lfsr_q[5:0], fb};
               if (cnt_q == CntW'(DATA_LEN - 1)) begin
                  state_d = StDone;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_scrambler_frame_tx.sv
// Self-checking bench for scrambler_frame_tx: scoreboard of expected serial bits plus
// whole-frame checks against a literal scrambler sequence and a descrambling loopback.
module tb_scrambler_frame_tx;

   localparam int unsigned PRE   = 12;
   localparam int unsigned SIG   = 24;
   localparam int unsigned DAT   = 48;
   localparam logic [6:0]  SEED  = 7'h7F;
   localparam int unsigned FRAME = PRE + SIG + DAT;
`ifdef TX_TAIL_ZERO_EN
   localparam int unsigned TAIL = 6;
`else
   localparam int unsigned TAIL = 0;
`endif

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic Start = 1'b0;
   logic In_data = 1'b0;
   logic In_valid = 1'b0;
   logic In_ready, Out, Out_valid, Busy, Done;

   int n_assert = 0;
   int n_fail   = 0;

   // Bench model state
   int         m_phase = 0;
   int         m_cnt   = 0;
   logic [6:0] m_lfsr  = SEED;
   logic       exp_ov   = 1'b0;
   logic       exp_busy = 1'b0;
   logic       exp_done = 1'b0;
   logic       sb[$];
   logic       cap[$];
   logic       src[SIG+DAT];
   logic       seq[DAT];
   int         src_idx  = 0;
   int         done_cnt = 0;

   scrambler_frame_tx #(
      .PREAMBLE_LEN(PRE),
      .SIGNAL_LEN  (SIG),
      .DATA_LEN    (DAT),
      .SEED        (SEED)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .In_data  (In_data),
      .In_valid (In_valid),
      .In_ready (In_ready),
      .Out      (Out),
      .Out_valid(Out_valid),
      .Busy     (Busy),
      .Done     (Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: check what the previous edge produced, drive inputs, advance the model.
   task automatic step(input logic rst, input logic start, input logic vld);
      logic b, f, ready, din;
      @(negedge Clk);
      chk("out_valid", Out_valid, exp_ov);
      chk("busy", Busy, exp_busy);
      chk("done", Done, exp_done);
      if (Done === 1'b1) done_cnt++;
      if (exp_ov && sb.size() > 0) begin
         b = sb.pop_front();
         chk("out", Out, b);
         cap.push_back(Out);
      end
      ready = (m_phase == 2) || (m_phase == 3);
      chk("in_ready", In_ready, ready);
      din      = (src_idx < SIG + DAT) ? src[src_idx] : 1'b0;
      Reset    = rst;
      Start    = start;
      In_valid = vld;
      In_data  = din;
      exp_ov   = 1'b0;
      exp_done = 1'b0;
      if (rst) begin
         m_phase  = 0;
         m_cnt    = 0;
         m_lfsr   = SEED;
         exp_busy = 1'b0;
         sb.delete();
      end else begin
         case (m_phase)
            0: if (start) begin
               m_phase  = 1;
               m_cnt    = 0;
               m_lfsr   = SEED;
               exp_busy = 1'b1;
            end
            1: begin
               sb.push_back(1'b1);
               exp_ov = 1'b1;
               if (m_cnt == PRE - 1) begin m_phase = 2; m_cnt = 0; end
               else m_cnt++;
            end
            2: if (vld) begin
               sb.push_back(din);
               exp_ov = 1'b1;
               src_idx++;
               if (m_cnt == SIG - 1) begin m_phase = 3; m_cnt = 0; end
               else m_cnt++;
            end
            3: if (vld) begin
               f = m_lfsr[6] ^ m_lfsr[3];
               b = din ^ f;
               if (m_cnt >= DAT - TAIL) b = 1'b0;
               sb.push_back(b);
               exp_ov = 1'b1;
               m_lfsr = {m_lfsr[5:0], f};
               src_idx++;
               if (m_cnt == DAT - 1) m_phase = 4;
               else m_cnt++;
            end
            default: begin
               exp_done = 1'b1;
               exp_busy = 1'b0;
               m_phase  = 0;
            end
         endcase
      end
   endtask

   // Runs one frame; abort_after >= 0 resets once that many DATA bits are accepted.
   task automatic run_frame(input bit gappy, input int abort_after, input bit extra_starts);
      bit fin = 1'b0;
      cap.delete();
      src_idx  = 0;
      done_cnt = 0;
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 400; i++) begin
         if (abort_after >= 0 && m_phase == 3 && m_cnt == abort_after) begin
            step(1'b1, 1'b0, 1'b0);
            fin = 1'b1;
            break;
         end
         step(1'b0, extra_starts && (m_phase != 0), gappy ? ((i % 2) == 0) : 1'b1);
         if (m_phase == 0) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) chk_int("frame_budget", 0, 1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
   endtask

   // Full-frame check against preamble ones, raw SIGNAL and seq-scrambled DATA.
   task automatic check_frame(input string tag);
      logic g;
      chk_int({tag, "_len"}, cap.size(), FRAME);
      chk_int({tag, "_done_count"}, done_cnt, 1);
      for (int i = 0; i < FRAME && i < cap.size(); i++) begin
         if (i < PRE) g = 1'b1;
         else if (i < PRE + SIG) g = src[i-PRE];
         else if (i - PRE - SIG >= DAT - TAIL) g = 1'b0;
         else g = src[i-PRE] ^ seq[i-PRE-SIG];
         chk({tag, "_bit"}, cap[i], g);
      end
   endtask

   initial begin
      logic [6:0]  s;
      logic [15:0] lit;
      logic        rec;

      s = SEED;
      for (int j = 0; j < DAT; j++) begin
         seq[j] = s[6] ^ s[3];
         s      = {s[5:0], seq[j]};
      end

      repeat (2) @(posedge Clk);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Gapless all-zero frame; DATA must show the raw SEED sequence
      for (int j = 0; j < SIG + DAT; j++) src[j] = 1'b0;
      run_frame(1'b0, -1, 1'b0);
      check_frame("gapless");
      lit = 16'b0000111011110010;
      for (int j = 0; j < 16; j++) chk("seed_seq", cap[PRE+SIG+j], lit[15-j]);

      // Same frame with In_valid toggling: bubbles, identical bit sequence
      run_frame(1'b1, -1, 1'b0);
      check_frame("bubbles");

      // Random loopback through a bench descrambler
      for (int j = 0; j < SIG + DAT; j++) src[j] = 1'($urandom_range(0, 1));
      run_frame(1'b0, -1, 1'b0);
      check_frame("loopback");
      for (int j = 0; j < SIG && PRE + j < cap.size(); j++)
         chk("loop_signal", cap[PRE+j], src[j]);
      for (int j = 0; j < DAT - TAIL && PRE + SIG + j < cap.size(); j++) begin
         rec = cap[PRE+SIG+j] ^ seq[j];
         chk("loop_data", rec, src[SIG+j]);
      end

      // Reset after 20 DATA transfers, then a clean frame from SEED
      run_frame(1'b0, 20, 1'b0);
      chk_int("abort_no_done", done_cnt, 0);
      chk_int("abort_bits", cap.size(), PRE + SIG + 20);
      run_frame(1'b0, -1, 1'b0);
      check_frame("after_abort");

      // Start held during the whole frame incl. DONE: one frame only
      run_frame(1'b0, -1, 1'b1);
      check_frame("extra_start");
      chk("idle_busy", Busy, 1'b0);

      // All-ones input: DATA = 1 ^ seq, tail zeroed when enabled
      for (int j = 0; j < SIG + DAT; j++) src[j] = 1'b1;
      run_frame(1'b0, -1, 1'b0);
      check_frame("ones");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
